// File: rtl/core_hazard_pipe_ctrl.sv
// Pipeline control for the 5-stage core: carries the D->X->M->W control bundle, detects load-use and
// branch-in-D hazards, drives forwarding selects and stall/flush. Define CORE_PERF_CNT_EN for perf counters.
module core_hazard_pipe_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_d,
    input  logic [1:0]            result_src_d,
    input  logic                  dmem_write_d,
    input  logic                  alu_src_d,
    input  logic [ALU_CTRL_W-1:0] alu_ctrl_d,
    input  logic                  branch_d,
    input  logic                  pc_src_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  dmem_stall,
    output logic                  alu_src_x,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_x,
    output logic                  dmem_write_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic [1:0]            forward_a_x,
    output logic [1:0]            forward_b_x,
    output logic                  forward_a_d,
    output logic                  forward_b_d,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_x,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [1:0] RES_LOAD = 2'b01;

    logic                  reg_write_x;
    logic [1:0]            result_src_x;
    logic                  dmem_write_x;
    logic [REG_ADDR_W-1:0] rs1_x;
    logic [REG_ADDR_W-1:0] rs2_x;
    logic [REG_ADDR_W-1:0] rd_x;

    logic                  reg_write_m;
    logic [1:0]            result_src_m;
    logic [REG_ADDR_W-1:0] rd_m;

    logic lw_stall;
    logic br_stall;
    logic hz;

    // A producer only matters when it writes a real register (x0 is never a source).
    function automatic logic src_match(input logic we, input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        if (m_hit)
            return 2'b10;
        else if (w_hit)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw_stall = src_match(result_src_x == RES_LOAD, rd_x, rs1_d)
                    | src_match(result_src_x == RES_LOAD, rd_x, rs2_d);

    assign br_stall = branch_d &&
                      (src_match(reg_write_x, rd_x, rs1_d)
                     | src_match(reg_write_x, rd_x, rs2_d)
                     | src_match(result_src_m == RES_LOAD, rd_m, rs1_d)
                     | src_match(result_src_m == RES_LOAD, rd_m, rs2_d));

    assign hz = lw_stall | br_stall;

    // A memory wait freezes everything upstream of W; only a hazard without one inserts an X bubble.
    assign stall_f = hz | dmem_stall;
    assign stall_d = hz | dmem_stall;
    assign flush_x = hz & ~dmem_stall;
    assign flush_d = pc_src_d & ~hz & ~dmem_stall;

    assign forward_a_x = fwd_sel(src_match(reg_write_m, rd_m, rs1_x), src_match(reg_write_w, rd_w, rs1_x));
    assign forward_b_x = fwd_sel(src_match(reg_write_m, rd_m, rs2_x), src_match(reg_write_w, rd_w, rs2_x));
    assign forward_a_d = src_match(reg_write_m, rd_m, rs1_d);
    assign forward_b_d = src_match(reg_write_m, rd_m, rs2_d);

    // D -> X
    always_ff @(posedge clk) begin
        if (reset || (flush_x && !dmem_stall)) begin
            reg_write_x  <= 1'b0;
            result_src_x <= 2'b00;
            dmem_write_x <= 1'b0;
            alu_src_x    <= 1'b0;
            alu_ctrl_x   <= '0;
            rs1_x        <= '0;
            rs2_x        <= '0;
            rd_x         <= '0;
        end else if (!dmem_stall) begin
            reg_write_x  <= reg_write_d;
            result_src_x <= result_src_d;
            dmem_write_x <= dmem_write_d;
            alu_src_x    <= alu_src_d;
            alu_ctrl_x   <= alu_ctrl_d;
            rs1_x        <= rs1_d;
            rs2_x        <= rs2_d;
            rd_x         <= rd_d;
        end
    end

    // X -> M
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            dmem_write_m <= 1'b0;
            rd_m         <= '0;
        end else if (!dmem_stall) begin
            reg_write_m  <= reg_write_x;
            result_src_m <= result_src_x;
            dmem_write_m <= dmem_write_x;
            rd_m         <= rd_x;
        end
    end

    // M -> W: a held M instruction must not retire twice, so W takes a bubble while memory waits.
    always_ff @(posedge clk) begin
        if (reset || dmem_stall) begin
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            rd_w         <= '0;
        end else begin
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
        end
    end

`ifdef CORE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_d || flush_x)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
